packet_deframer: RTL

Receive-side counterpart of the sensor packet framer: consumes the 9-byte framed byte stream (start delimiter, sensor ID, length, timestamp, data, checksum, end delimiter), checks structure and the two's-complement checksum, and presents each good packet as one parallel record. It sits at the host/loopback end of the link, between the byte transport (UART RX or loopback) and the consumer logic or bench scoreboard. Bad frames are dropped and counted, and the parser resynchronises on the next start delimiter.

---
 rtl/iot_sensor_pkg.sv | 17 +
 rtl/packet_deframer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/iot_sensor_pkg.sv
// Shared constants and types for the sensor packet link (framer and deframer).
package iot_sensor_pkg;

  localparam logic [7:0] PACKET_START_DELIM = 8'h7E;
  localparam logic [7:0] PACKET_END_DELIM   = 8'h7E;
  localparam logic [7:0] PACKET_LENGTH      = 8'h09;
  localparam int         PACKET_BYTES       = 9;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_DELIM,
    ERR_LENGTH,
    ERR_FORMAT,
    ERR_CHECKSUM
  } deframe_err_e;

endpackage

// File: rtl/packet_deframer.sv
// Positional parser for 9-byte sensor frames: checks delimiters, length, ID format and checksum,
// presents good packets as one held record, drops and counts bad frames.
module packet_deframer
  import iot_sensor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] sensor_data,
  output logic [1:0]  sensor_id,
  output logic [15:0] timestamp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_delim,
  output logic        err_length,
  output logic        err_format,
  output logic        err_checksum,
  output logic [15:0] pkt_ok_count,
  output logic [15:0] pkt_err_count,
  output logic [3:0]  parse_state_debug
);

  localparam logic [3:0] S_HUNT = 4'd0;
  localparam logic [3:0] S_ID   = 4'd1;
  localparam logic [3:0] S_LEN  = 4'd2;
  localparam logic [3:0] S_TSH  = 4'd3;
  localparam logic [3:0] S_TSL  = 4'd4;
  localparam logic [3:0] S_DH   = 4'd5;
  localparam logic [3:0] S_DL   = 4'd6;
  localparam logic [3:0] S_CHK  = 4'd7;
  localparam logic [3:0] S_END  = 4'd8;

  logic [3:0]   r_state;
  logic [7:0]   r_sum;
  logic         r_chk_ok;
  logic [1:0]   r_id_sh;
  logic [15:0]  r_ts_sh;
  logic [15:0]  r_data_sh;
  logic         r_out_valid;
  logic [1:0]   r_sensor_id;
  logic [15:0]  r_timestamp;
  logic [15:0]  r_sensor_data;
  logic         r_err_delim;
  logic         r_err_length;
  logic         r_err_format;
  logic         r_err_checksum;
  logic [15:0]  r_ok_count;
  logic [15:0]  r_err_count;

  logic         w_accept;
  logic [7:0]   w_sum_add;
  logic [3:0]   w_next_state;
  logic [7:0]   w_next_sum;
  logic         w_good;
  deframe_err_e w_err;

  // Holding off input while a record is pending guarantees it is never overwritten.
  assign rx_ready  = enable && !r_out_valid;
  assign w_accept  = rx_valid && rx_ready;
  assign w_sum_add = r_sum + rx_byte;

  always_comb begin
    w_next_state = r_state;
    w_next_sum   = r_sum;
    w_err        = ERR_NONE;
    w_good       = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HUNT: begin
          if (rx_byte == PACKET_START_DELIM) begin
            w_next_state = S_ID;
            w_next_sum   = PACKET_START_DELIM;
          end
        end
        S_ID: begin
          // A repeated delimiter is treated as a fresh frame start.
          if (rx_byte == PACKET_START_DELIM) begin
            w_next_sum = PACKET_START_DELIM;
          end else if (rx_byte[7:2] != 6'd0) begin
            w_err        = ERR_FORMAT;
            w_next_state = S_HUNT;
          end else begin
            w_next_state = S_LEN;
            w_next_sum   = w_sum_add;
          end
        end
        S_LEN: begin
          if (rx_byte != PACKET_LENGTH) begin
            w_err        = ERR_LENGTH;
            w_next_state = S_HUNT;
          end else begin
            w_next_state = S_TSH;
            w_next_sum   = w_sum_add;
          end
        end
        S_TSH, S_TSL, S_DH, S_DL: begin
          w_next_state = r_state + 4'd1;
          w_next_sum   = w_sum_add;
        end
        S_CHK: w_next_state = S_END;
        S_END: begin
          w_next_state = S_HUNT;
          if (rx_byte != PACKET_END_DELIM) w_err = ERR_DELIM;
          else if (!r_chk_ok)              w_err = ERR_CHECKSUM;
          else                             w_good = 1'b1;
        end
        default: w_next_state = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_HUNT;
      r_sum          <= 8'h00;
      r_chk_ok       <= 1'b0;
      r_id_sh        <= 2'd0;
      r_ts_sh        <= 16'h0000;
      r_data_sh      <= 16'h0000;
      r_out_valid    <= 1'b0;
      r_sensor_id    <= 2'd0;
      r_timestamp    <= 16'h0000;
      r_sensor_data  <= 16'h0000;
      r_err_delim    <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_format   <= 1'b0;
      r_err_checksum <= 1'b0;
      r_ok_count     <= 16'h0000;
      r_err_count    <= 16'h0000;
    end else if (!enable) begin
      r_state        <= S_HUNT;
      r_sum          <= 8'h00;
      r_out_valid    <= 1'b0;
      r_err_delim    <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_format   <= 1'b0;
      r_err_checksum <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_sum          <= w_next_sum;
      r_err_delim    <= (w_err == ERR_DELIM);
      r_err_length   <= (w_err == ERR_LENGTH);
      r_err_format   <= (w_err == ERR_FORMAT);
      r_err_checksum <= (w_err == ERR_CHECKSUM);
      if (w_accept) begin
        case (r_state)
          S_ID:    r_id_sh         <= rx_byte[1:0];
          S_TSH:   r_ts_sh[15:8]   <= rx_byte;
          S_TSL:   r_ts_sh[7:0]    <= rx_byte;
          S_DH:    r_data_sh[15:8] <= rx_byte;
          S_DL:    r_data_sh[7:0]  <= rx_byte;
          S_CHK:   r_chk_ok        <= (w_sum_add == 8'h00);
          default: ;
        endcase
      end
      if (w_good) begin
        r_out_valid   <= 1'b1;
        r_sensor_id   <= r_id_sh;
        r_timestamp   <= r_ts_sh;
        r_sensor_data <= r_data_sh;
        if (r_ok_count != 16'hFFFF) r_ok_count <= r_ok_count + 16'd1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_err != ERR_NONE && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign out_valid         = r_out_valid;
  assign sensor_id         = r_sensor_id;
  assign timestamp         = r_timestamp;
  assign sensor_data       = r_sensor_data;
  assign err_delim         = r_err_delim;
  assign err_length        = r_err_length;
  assign err_format        = r_err_format;
  assign err_checksum      = r_err_checksum;
  assign pkt_ok_count      = r_ok_count;
  assign pkt_err_count     = r_err_count;
  assign parse_state_debug = r_state;

endmodule
